sha_round_ctrl: RTL and testbench
=================================

Name: sha_round_ctrl

Overview:
- Sequencer for one SHA-256 compression of a 512-bit message block.
- Drives the load enables of the 16-word message-schedule registers, the working-variable registers (a..h) and the hash registers (H0..H7).
- Accepts 16 message words through a valid/ready handshake, runs ROUNDS rounds, folds the result into H and pulses done.
- Sits between the host/padding front end and the register/round datapath.

Parameters:
- ROUNDS, 64, number of compression rounds per block.
- WORDS, 16, message words per block.
- CNT_W, 7, width of the round/word counter; must satisfy 2^CNT_W > ROUNDS.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- start  input  1  begin one block; sampled only in IDLE.
- init  input  1  sampled with start; 1 = first block of a message (load IV into H).
- msg_valid  input  1  message word present on the datapath input.
- msg_ready  output  1  controller accepts a word this cycle.
- word_idx  output  4  index of the word being loaded (0..WORDS-1).
- w_load_en  output  1  write current word into the schedule register word_idx.
- w_shift_en  output  1  advance the message schedule one step.
- hash_init_en  output  1  load IV constants into H0..H7.
- state_load_en  output  1  copy H0..H7 into a..h.
- round_en  output  1  execute one round in the datapath.
- round_idx  output  CNT_W  current round number, selects K constant.
- hash_update_en  output  1  H[i] <= H[i] + working[i].
- busy  output  1  block in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE. Counter cnt is CNT_W bits.
- Reset (RST=1 at clock edge):
  - State goes to IDLE and cnt to 0.
  - All outputs read 0 the next cycle.
  - Applies from any state; an in-flight block is abandoned with no done pulse.
- IDLE:
  - busy=0, msg_ready=0.
  - start=1 → LOAD, cnt <= 0.
  - If init=1 on that same cycle, hash_init_en=1 for that cycle (Mealy output).
  - start with init=0 keeps H unchanged (chained block).
- LOAD:
  - busy=1, msg_ready=1, word_idx=cnt[3:0].
  - w_load_en = msg_valid & msg_ready (combinational).
  - Each handshake increments cnt.
  - No handshake: hold state and cnt; no timeout.
  - Handshake with cnt==WORDS-1: state_load_en=1 in that cycle, then → ROUND with cnt <= 0.
- ROUND:
  - busy=1, round_en=1, round_idx=cnt, w_shift_en=1 every cycle. No stalling.
  - cnt==ROUNDS-1 → FINAL, cnt <= 0.
- FINAL: busy=1, hash_update_en=1 for exactly one cycle → DONE.
- DONE:
  - done=1, busy=0 for one cycle → IDLE.
  - start is ignored in DONE; a new block needs start in IDLE.
- start or init asserted in any state other than IDLE: no effect.
- msg_valid outside LOAD: ignored; w_load_en=0.
- Enables are mutually exclusive per cycle, except state_load_en with the final w_load_en.
- Latency, start sampled at T0 and msg_valid held high:
  - Words are accepted T1..T16.
  - round_en is high T17..T80.
  - hash_update_en is high at T81.
  - done is high at T82.
  - Start-to-done = 82 cycles + stall cycles in LOAD.

Optional Feature:
- Macro: SHA_ROUND_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in LOAD, ROUND or FINAL → IDLE next cycle with cnt <= 0.
  - No hash_update_en and no done pulse.
  - H registers unchanged unless FINAL had already completed.
  - abort has lower priority than RST.
  - abort in IDLE or DONE: no effect.
- Undefined: no abort port; a block can only be terminated by RST.

Test Plan:
- Reset then single block: RST 1 for 2 cycles, start=1 with init=1, msg_valid held 1 → hash_init_en high at T0; w_load_en at T1..T16 with word_idx 0..15; state_load_en at T16; round_idx 0..63 at T17..T80; hash_update_en at T81; done at T82; busy low at T82.
- Stalled LOAD: msg_valid low for 3 cycles after word 5 → word_idx holds at 6; w_load_en=0 during the stall; done at T85.
- Chained block: second start with init=0 in the cycle after done → no hash_init_en; identical 82-cycle sequence; start asserted during DONE ignored.
- Mid-operation reset: RST=1 at round 30 → outputs 0 next cycle; state IDLE; no hash_update_en or done; a subsequent start runs a full clean block.
- Spurious inputs: start and msg_valid toggled during ROUND → no change to round_idx progression or w_load_en.
- With SHA_ROUND_CTRL_ABORT_EN: abort at round 10 → busy=0 next cycle; hash_update_en and done never asserted; the next start works normally.

Source files
------------

// File: rtl/sha_round_ctrl.sv
// -----------------------------------------------------------------------------
// sha_round_ctrl
//
// Sequencer for one SHA-256 compression of a 512-bit message block. It takes
// the 16 message words in over a valid/ready handshake, runs ROUNDS rounds,
// folds the working variables back into H and then pulses done. It sits
// between the host/padding front end and the register/round datapath.
//
// Build option:
//   SHA_ROUND_CTRL_ABORT_EN - when defined, adds an 'abort' input. Asserting
//   abort in LOAD, ROUND or FINAL drops the block: the controller returns to
//   IDLE, hash_update_en is never raised and done never pulses. RST still
//   has priority over abort.
//
// Ports:
//   CLK            in   clock; all logic is on the rising edge
//   RST            in   synchronous active-high reset
//   start          in   begin one block (sampled only in IDLE)
//   init           in   sampled with start; 1 = first block, load IV into H
//   msg_valid      in   message word present on the datapath input
//   abort          in   (optional) drop the block in flight
//   msg_ready      out  controller accepts a word this cycle
//   word_idx       out  schedule register index of the word being loaded
//   w_load_en      out  write the current word into schedule reg word_idx
//   w_shift_en     out  advance the message schedule one step
//   hash_init_en   out  load IV constants into H0..H7
//   state_load_en  out  copy H0..H7 into a..h
//   round_en       out  execute one round in the datapath
//   round_idx      out  current round number (selects K constant)
//   hash_update_en out  H[i] <= H[i] + working[i]
//   busy           out  block in progress
//   done           out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module sha_round_ctrl #(
    parameter int ROUNDS = 64,
    parameter int WORDS  = 16,
    parameter int CNT_W  = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             init,
    input  logic             msg_valid,
`ifdef SHA_ROUND_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             msg_ready,
    output logic [3:0]       word_idx,
    output logic             w_load_en,
    output logic             w_shift_en,
    output logic             hash_init_en,
    output logic             state_load_en,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             hash_update_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Word handshake: msg_ready is high in every LOAD cycle, so a valid word
    // in LOAD is always accepted.
    logic load_hs;
    assign load_hs = (state_reg == S_LOAD) && msg_valid;

`ifdef SHA_ROUND_CTRL_ABORT_EN
    // abort only matters while a block is actually in flight.
    logic abort_hit;
    assign abort_hit = abort && ((state_reg == S_LOAD)  ||
                                 (state_reg == S_ROUND) ||
                                 (state_reg == S_FINAL));
`endif

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    cnt_next   = '0;
                end
            end
            S_LOAD: begin
                // Without a handshake the counter simply holds; there is no
                // timeout, the front end may stall indefinitely.
                if (load_hs) begin
                    if (cnt_reg == LAST_WORD) begin
                        state_next = S_ROUND;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end
            S_ROUND: begin
                if (cnt_reg == LAST_ROUND) begin
                    state_next = S_FINAL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_FINAL: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                // start is deliberately not looked at here; a new block has
                // to be requested from IDLE.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
`ifdef SHA_ROUND_CTRL_ABORT_EN
        if (abort_hit) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        msg_ready      = 1'b0;
        word_idx       = '0;
        w_load_en      = 1'b0;
        w_shift_en     = 1'b0;
        hash_init_en   = 1'b0;
        state_load_en  = 1'b0;
        round_en       = 1'b0;
        round_idx      = '0;
        hash_update_en = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Mealy: the IV load happens in the very cycle start is seen,
                // so H is ready long before the first round needs it.
                hash_init_en = start && init;
            end
            S_LOAD: begin
                busy      = 1'b1;
                msg_ready = 1'b1;
                word_idx  = cnt_reg[3:0];
                w_load_en = load_hs;
                // a..h are loaded alongside the last word so the first round
                // can start on the next cycle.
                state_load_en = load_hs && (cnt_reg == LAST_WORD);
            end
            S_ROUND: begin
                busy       = 1'b1;
                round_en   = 1'b1;
                w_shift_en = 1'b1;
                round_idx  = cnt_reg;
            end
            S_FINAL: begin
                busy = 1'b1;
`ifdef SHA_ROUND_CTRL_ABORT_EN
                // An abort in FINAL must leave H untouched.
                hash_update_en = !abort;
`else
                hash_update_en = 1'b1;
`endif
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha_round_ctrl
//
// Directed bench for sha_round_ctrl. A short table of per-cycle vectors covers
// reset and the start of LOAD; hand-written block sequences then walk whole
// compressions cycle by cycle (plain, chained, stalled, reset mid-round and,
// when SHA_ROUND_CTRL_ABORT_EN is defined, aborted), with the expected outputs
// derived from the block timing: start at T0, LOAD from T1, rounds after the
// 16th accepted word, FINAL, then DONE.
// -----------------------------------------------------------------------------
module tb_sha_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int WORDS  = 16;
    localparam int CNT_W  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             init;
    logic             msg_valid;
`ifdef SHA_ROUND_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             msg_ready;
    logic [3:0]       word_idx;
    logic             w_load_en;
    logic             w_shift_en;
    logic             hash_init_en;
    logic             state_load_en;
    logic             round_en;
    logic [CNT_W-1:0] round_idx;
    logic             hash_update_en;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    sha_round_ctrl #(
        .ROUNDS(ROUNDS),
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .start         (start),
        .init          (init),
        .msg_valid     (msg_valid),
`ifdef SHA_ROUND_CTRL_ABORT_EN
        .abort         (abort),
`endif
        .msg_ready     (msg_ready),
        .word_idx      (word_idx),
        .w_load_en     (w_load_en),
        .w_shift_en    (w_shift_en),
        .hash_init_en  (hash_init_en),
        .state_load_en (state_load_en),
        .round_en      (round_en),
        .round_idx     (round_idx),
        .hash_update_en(hash_update_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // All outputs packed together so one compare covers a whole cycle.
    typedef struct packed {
        logic       ready;
        logic [3:0] widx;
        logic       wload;
        logic       wshift;
        logic       hinit;
        logic       sload;
        logic       ren;
        logic [6:0] ridx;
        logic       hupd;
        logic       busy;
        logic       done;
    } out_t;

    out_t act;
    assign act = {msg_ready, word_idx, w_load_en, w_shift_en, hash_init_en,
                  state_load_en, round_en, round_idx, hash_update_en, busy, done};

    typedef struct {
        string name;
        bit    rst;
        bit    start;
        bit    init;
        bit    valid;
        out_t  exp;
    } vec_t;

    vec_t vecs[12];

    function automatic out_t o_idle(input bit hinit);
        out_t o;
        o       = '0;
        o.hinit = hinit;
        return o;
    endfunction

    function automatic out_t o_load(input int idx, input bit wl, input bit sl);
        out_t o;
        o       = '0;
        o.ready = 1'b1;
        o.busy  = 1'b1;
        o.widx  = 4'(idx);
        o.wload = wl;
        o.sload = sl;
        return o;
    endfunction

    function automatic vec_t mk(input string n, input bit r, input bit s,
                                input bit i, input bit v, input out_t e);
        vec_t x;
        x.name  = n;
        x.rst   = r;
        x.start = s;
        x.init  = i;
        x.valid = v;
        x.exp   = e;
        return x;
    endfunction

    // Drive one cycle's inputs just after the rising edge, then stop at the
    // falling edge where the outputs are sampled.
    task automatic drive(input bit r, input bit s, input bit i, input bit v, input bit a);
        @(posedge clk);
        #1;
        rst       = r;
        start     = s;
        init      = i;
        msg_valid = v;
`ifdef SHA_ROUND_CTRL_ABORT_EN
        abort     = a;
`else
        if (a) $display("note: abort requested but not built in");
`endif
        @(negedge clk);
    endtask

    task automatic check(input string name, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, act, exp);
        end
    endtask

    // One block starting with start at t=0 (DUT must be in IDLE). stall>0
    // drops msg_valid for that many cycles right after word 5. rst_at/abort_at
    // terminate the block in that cycle (-1 = never); the bench then checks
    // four idle cycles in which msg_valid toggles and nothing may respond.
    task automatic run_block(input string tag, input bit ini, input int stall,
                             input bit spurious, input int rst_at,
                             input int abort_at, input bit start_in_done);
        int   last_load;
        int   acc;
        out_t e;
        bit   s, i, v, r, a;
        last_load = WORDS + stall;
        acc       = 0;
        for (int t = 0; t <= last_load + ROUNDS + 2; t++) begin
            s = 1'b0; i = 1'b0; v = 1'b0; r = 1'b0; a = 1'b0;
            e = '0;
            if (t == 0) begin
                s       = 1'b1;
                i       = ini;
                e.hinit = ini;
            end else if (t <= last_load) begin
                v       = !(stall > 0 && t >= 7 && t <= 6 + stall);
                e.ready = 1'b1;
                e.busy  = 1'b1;
                e.widx  = 4'(acc);
                e.wload = v;
                e.sload = v && (acc == WORDS - 1);
            end else if (t <= last_load + ROUNDS) begin
                e.busy   = 1'b1;
                e.ren    = 1'b1;
                e.wshift = 1'b1;
                e.ridx   = 7'(t - last_load - 1);
                if (spurious) begin
                    s = t[0];
                    i = 1'b1;
                    v = !t[0];
                end
            end else if (t == last_load + ROUNDS + 1) begin
                e.busy = 1'b1;
                e.hupd = 1'b1;
            end else begin
                e.done = 1'b1;
                if (start_in_done) begin
                    s = 1'b1;
                    i = 1'b1;
                end
            end
            if (t == rst_at)   r = 1'b1;
            if (t == abort_at) a = 1'b1;
            drive(r, s, i, v, a);
            check($sformatf("%s_t%0d", tag, t), e);
            if (v && t >= 1 && t <= last_load) acc++;
            if (r || a) begin
                for (int k = 0; k < 4; k++) begin
                    drive(1'b0, 1'b0, 1'b0, k[0], 1'b0);
                    check($sformatf("%s_post%0d", tag, k), '0);
                end
                return;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        init      = 1'b0;
        msg_valid = 1'b0;
`ifdef SHA_ROUND_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        // Reset held for two edges before the table starts.
        repeat (2) @(posedge clk);

        //                 name            rst   start init  valid expected
        vecs[0]  = mk("rst_idle",      1'b1, 1'b0, 1'b0, 1'b1, o_idle(1'b0));
        vecs[1]  = mk("idle_valid",    1'b0, 1'b0, 1'b1, 1'b1, o_idle(1'b0));
        vecs[2]  = mk("idle_quiet",    1'b0, 1'b0, 1'b0, 1'b0, o_idle(1'b0));
        vecs[3]  = mk("start_init",    1'b0, 1'b1, 1'b1, 1'b1, o_idle(1'b1));
        vecs[4]  = mk("load_w0",       1'b0, 1'b0, 1'b0, 1'b1, o_load(0, 1'b1, 1'b0));
        vecs[5]  = mk("load_w1_stall", 1'b0, 1'b0, 1'b0, 1'b0, o_load(1, 1'b0, 1'b0));
        vecs[6]  = mk("load_w1_rst",   1'b1, 1'b0, 1'b0, 1'b1, o_load(1, 1'b1, 1'b0));
        vecs[7]  = mk("after_rst",     1'b0, 1'b0, 1'b0, 1'b1, o_idle(1'b0));
        vecs[8]  = mk("start_chain",   1'b0, 1'b1, 1'b0, 1'b0, o_idle(1'b0));
        vecs[9]  = mk("load_w0_wait",  1'b0, 1'b0, 1'b0, 1'b0, o_load(0, 1'b0, 1'b0));
        vecs[10] = mk("load_rst",      1'b1, 1'b1, 1'b1, 1'b0, o_load(0, 1'b0, 1'b0));
        vecs[11] = mk("rst_released",  1'b0, 1'b0, 1'b0, 1'b0, o_idle(1'b0));

        for (int n = 0; n < 12; n++) begin
            drive(vecs[n].rst, vecs[n].start, vecs[n].init, vecs[n].valid, 1'b0);
            check(vecs[n].name, vecs[n].exp);
        end

        // Full block with IV load; start+init during DONE must be ignored.
        run_block("blk1", 1'b1, 0, 1'b0, -1, -1, 1'b1);
        // Chained block in the cycle after done, with junk inputs in ROUND.
        run_block("chain", 1'b0, 0, 1'b1, -1, -1, 1'b0);
        // Three stall cycles after word 5: done lands at T85.
        run_block("stall", 1'b1, 3, 1'b0, -1, -1, 1'b0);
        // Reset during round 30 (T47), then a clean block.
        run_block("midrst", 1'b1, 0, 1'b0, WORDS + 1 + 30, -1, 1'b0);
        run_block("clean", 1'b1, 0, 1'b0, -1, -1, 1'b0);
`ifdef SHA_ROUND_CTRL_ABORT_EN
        // Abort at round 10 (T27), then a normal block.
        run_block("abort", 1'b1, 0, 1'b0, -1, WORDS + 1 + 10, 1'b0);
        run_block("after_abort", 1'b0, 0, 1'b0, -1, -1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
